t_count_ctrl: RTL and testbench

// Sequencer for a WIDTH-bit bank of toggle flip-flops forming a synchronous counter.

---
 rtl/t_count_ctrl.sv | 121 ++++++++++++
 tb/tb_t_count_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/t_count_ctrl.sv
// Sequencer driving a WIDTH-bit toggle flip-flop bank as an up/down counter
// with one-shot or wrap termination, pause/resume and abort.
module t_count_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             wrap,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] T_out,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0] start_val, end_val, step_t, load_val;
  logic             load, carry;

  assign start_val = dir_q ? limit_q : '0;
  assign end_val   = dir_q ? '0 : limit_q;
  assign load_val  = dir ? limit : '0;

  // Ripple toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down).
  // NOTE: blocking assignments here are intentional; carry is a combinational
  // temporary that must see the value from the previous loop iteration.
  always_comb begin
    step_t = '0;
    carry  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      step_t[i] = carry;
      carry     = carry & (dir_q ? ~q_q[i] : q_q[i]);
    end
  end

  assign tc = (state_q == S_RUN) && (q_q == end_val);

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    wrap_d  = wrap_q;
    limit_d = limit_q;
    T_out   = '0;
    load    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !stop) begin
          load    = 1'b1;
          dir_d   = dir;
          wrap_d  = wrap;
          limit_d = limit;
          state_d = S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (stop) begin
          state_d = S_PAUSE;
        end else if (tc) begin
          if (wrap_q) T_out = q_q ^ start_val;
          else        state_d = S_DONE;
        end else begin
          T_out = step_t;
        end
      end
      S_PAUSE: begin
        if (stop)       state_d = S_IDLE;
        else if (start) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    // The bank only ever toggles, except for the start-value load.
    q_d = load ? load_val : (q_q ^ T_out);
  end

  // NOTE: non-blocking assignments so all registers update from the same
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      dir_q   <= 1'b0;
      wrap_q  <= 1'b0;
      limit_q <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      limit_q <= limit_d;
    end
  end

  assign Q    = q_q;
  assign Qn   = ~q_q;
  assign busy = (state_q == S_RUN) || (state_q == S_PAUSE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_t_count_ctrl.sv
// Bench for t_count_ctrl: directed scenarios plus randomized traffic checked
// against an arithmetic reference model of the counter.
module tb_t_count_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1, start = 1'b0, stop = 1'b0, dir = 1'b0, wrap = 1'b0;
  logic [W-1:0] limit = '0;
  logic [W-1:0] Q, Qn, T_out;
  logic         busy, done, tc;

  int n_cmp = 0;
  int n_err = 0;

  t_count_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .dir(dir), .wrap(wrap),
    .limit(limit), .Q(Q), .Qn(Qn), .T_out(T_out), .busy(busy), .done(done), .tc(tc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: mode number plus an integer count.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int           m_st = M_IDLE;
  logic [W-1:0] m_q = '0, m_lim = '0;
  logic         m_dir = 1'b0, m_wrap = 1'b0;

  function automatic logic [W-1:0] m_start();
    return m_dir ? m_lim : '0;
  endfunction

  function automatic logic [W-1:0] m_end();
    return m_dir ? '0 : m_lim;
  endfunction

  function automatic logic [W-1:0] m_run_next();
    if (m_q == m_end()) return m_wrap ? m_start() : m_q;
    return m_dir ? m_q - 1'b1 : m_q + 1'b1;
  endfunction

  function automatic logic [W-1:0] m_exp_t();
    return (m_st == M_RUN && !stop) ? (m_q ^ m_run_next()) : '0;
  endfunction

  task automatic model_update();
    if (rst) begin
      m_st = M_IDLE; m_q = '0; m_dir = 1'b0; m_wrap = 1'b0; m_lim = '0;
    end else begin
      case (m_st)
        M_IDLE, M_DONE: begin
          if (start && !stop) begin
            m_dir = dir; m_wrap = wrap; m_lim = limit;
            m_q = m_start(); m_st = M_RUN;
          end else if (m_st == M_DONE) m_st = M_IDLE;
        end
        M_RUN: begin
          if (stop) m_st = M_PAUSE;
          else if (m_q == m_end() && !m_wrap) m_st = M_DONE;
          else m_q = m_run_next();
        end
        M_PAUSE: begin
          if (stop) m_st = M_IDLE;
          else if (start) m_st = M_RUN;
        end
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; dir = 1'($urandom); wrap = 1'($urandom); limit = W'($urandom);
    start = 1'b1; tick(); start = 1'b0;
    repeat ($urandom_range(1, 8)) tick();
    rst = 1'b1; tick(); tick(); #1;
    n_cmp++; if (Q !== 4'b0000) begin n_err++; $display("FAIL reset_q: got %b want 0000", Q); end
    n_cmp++; if (Qn !== 4'b1111) begin n_err++; $display("FAIL reset_qn: got %b want 1111", Qn); end
    n_cmp++; if (T_out !== 4'b0000) begin n_err++; $display("FAIL reset_t: got %b want 0000", T_out); end
    n_cmp++; if ({busy, done, tc} !== 3'b000) begin n_err++; $display("FAIL reset_flags: busy/done/tc got %b want 000", {busy, done, tc}); end
    rst = 1'b0;
  endtask

  task automatic test_oneshot_up();
    logic [3:0] exp_tv [5] = '{4'b0001, 4'b0011, 4'b0001, 4'b0111, 4'b0001};
    dir = 1'b0; wrap = 1'b0; limit = 4'd5; start = 1'b1;
    tick(); start = 1'b0; #1;
    for (int i = 0; i <= 5; i++) begin
      n_cmp++; if (Q !== 4'(i)) begin n_err++; $display("FAIL up_q[%0d]: got %0d want %0d", i, Q, i); end
      n_cmp++; if (T_out !== (i < 5 ? exp_tv[i] : 4'b0000)) begin n_err++; $display("FAIL up_t[%0d]: got %b want %b", i, T_out, (i < 5 ? exp_tv[i] : 4'b0000)); end
      n_cmp++; if (tc !== (i == 5)) begin n_err++; $display("FAIL up_tc[%0d]: got %b want %b", i, tc, (i == 5)); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL up_early_done[%0d]: got %b want 0", i, done); end
      tick();
    end
    n_cmp++; if ({done, busy, Q} !== {1'b1, 1'b0, 4'd5}) begin n_err++; $display("FAIL up_done: done/busy/Q got %b/%b/%0d want 1/0/5", done, busy, Q); end
    tick();
    n_cmp++; if ({done, Q} !== {1'b0, 4'd5}) begin n_err++; $display("FAIL up_after: done/Q got %b/%0d want 0/5", done, Q); end
  endtask

  task automatic test_wrap_down();
    logic [3:0] eq;
    dir = 1'b1; wrap = 1'b1; limit = 4'd3; start = 1'b1;
    tick(); start = 1'b0; #1;
    for (int i = 0; i < 10; i++) begin
      eq = 4'(3 - (i % 4));
      n_cmp++; if (Q !== eq) begin n_err++; $display("FAIL dn_q[%0d]: got %0d want %0d", i, Q, eq); end
      n_cmp++; if (tc !== (eq == 0)) begin n_err++; $display("FAIL dn_tc[%0d]: got %b want %b", i, tc, (eq == 0)); end
      n_cmp++; if (T_out !== (eq == 0 ? 4'b0011 : eq ^ (eq - 4'd1))) begin n_err++; $display("FAIL dn_t[%0d]: got %b want %b", i, T_out, (eq == 0 ? 4'b0011 : eq ^ (eq - 4'd1))); end
      tick();
    end
    stop = 1'b1; tick(); tick(); stop = 1'b0; #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dn_abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_pause_abort();
    logic done_seen = 1'b0;
    dir = 1'b0; wrap = 1'b0; limit = 4'd9; start = 1'b1;
    tick(); start = 1'b0; tick(); tick(); #1;
    n_cmp++; if (Q !== 4'd2) begin n_err++; $display("FAIL pz_pre_q: got %0d want 2", Q); end
    stop = 1'b1; #1;
    n_cmp++; if (T_out !== 4'b0000) begin n_err++; $display("FAIL pz_stop_t: got %b want 0000", T_out); end
    tick(); stop = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if ({busy, T_out, Q} !== {1'b1, 4'b0000, 4'd2}) begin n_err++; $display("FAIL pz_hold[%0d]: busy/T/Q got %b/%b/%0d want 1/0000/2", i, busy, T_out, Q); end
      done_seen |= done;
      tick();
    end
    start = 1'b1; tick(); start = 1'b0; #1;
    n_cmp++; if (Q !== 4'd2) begin n_err++; $display("FAIL pz_resume_q: got %0d want 2", Q); end
    tick();
    n_cmp++; if (Q !== 4'd3) begin n_err++; $display("FAIL pz_count3: got %0d want 3", Q); end
    tick();
    n_cmp++; if (Q !== 4'd4) begin n_err++; $display("FAIL pz_count4: got %0d want 4", Q); end
    stop = 1'b1; tick(); done_seen |= done; tick(); done_seen |= done; stop = 1'b0; #1;
    n_cmp++; if ({busy, Q} !== {1'b0, 4'd4}) begin n_err++; $display("FAIL pz_abort: busy/Q got %b/%0d want 0/4", busy, Q); end
    n_cmp++; if (done_seen !== 1'b0) begin n_err++; $display("FAIL pz_no_done: got %b want 0", done_seen); end
  endtask

  task automatic test_start_stop_limit0();
    start = 1'b1; stop = 1'b1; limit = 4'd7;
    tick(); start = 1'b0; stop = 1'b0; #1;
    n_cmp++; if ({busy, Q} !== {1'b0, 4'd4}) begin n_err++; $display("FAIL ss_idle: busy/Q got %b/%0d want 0/4", busy, Q); end
    dir = 1'b0; wrap = 1'b0; limit = 4'd0; start = 1'b1;
    tick(); start = 1'b0; #1;
    n_cmp++; if ({tc, done, T_out, Q} !== {1'b1, 1'b0, 4'b0, 4'd0}) begin n_err++; $display("FAIL l0_tc: tc/done/T/Q got %b/%b/%b/%0d want 1/0/0000/0", tc, done, T_out, Q); end
    tick();
    n_cmp++; if ({tc, done, Q} !== {1'b0, 1'b1, 4'd0}) begin n_err++; $display("FAIL l0_done: tc/done/Q got %b/%b/%0d want 0/1/0", tc, done, Q); end
    tick();
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL l0_pulse: got %b want 0", done); end
    wrap = 1'b1; start = 1'b1; tick(); start = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({busy, tc, T_out, Q} !== {1'b1, 1'b1, 4'b0, 4'd0}) begin n_err++; $display("FAIL l0_wrap[%0d]: busy/tc/T/Q got %b/%b/%b/%0d want 1/1/0000/0", i, busy, tc, T_out, Q); end
      tick();
    end
    stop = 1'b1; tick(); tick(); stop = 1'b0;
  endtask

  task automatic test_rst_midrun();
    logic got_done = 1'b0;
    dir = 1'b0; wrap = 1'b0; limit = 4'd9; start = 1'b1;
    tick(); start = 1'b0;
    repeat (6) tick();
    n_cmp++; if (Q !== 4'd6) begin n_err++; $display("FAIL rr_pre: got %0d want 6", Q); end
    rst = 1'b1; tick(); rst = 1'b0; #1;
    n_cmp++; if ({Q, busy, done} !== {4'd0, 1'b0, 1'b0}) begin n_err++; $display("FAIL rr_reset: Q/busy/done got %0d/%b/%b want 0/0/0", Q, busy, done); end
    start = 1'b1; tick(); start = 1'b0; tick(); tick();
    limit = 4'd2;
    for (int i = 0; i < 20 && !got_done; i++) begin
      tick();
      got_done = done;
    end
    n_cmp++; if ({got_done, Q} !== {1'b1, 4'd9}) begin n_err++; $display("FAIL rr_limit_ignored: done/Q got %b/%0d want 1/9", got_done, Q); end
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst   = ($urandom_range(0, 39) == 0);
      start = ($urandom_range(0, 3) == 0);
      stop  = ($urandom_range(0, 7) == 0);
      dir   = 1'($urandom);
      wrap  = 1'($urandom);
      limit = W'($urandom);
      #1;
      n_cmp++; if ({Q, Qn} !== {m_q, ~m_q}) begin n_err++; $display("FAIL rnd_q[%0d]: got %b/%b want %b/%b", i, Q, Qn, m_q, ~m_q); end
      n_cmp++; if (T_out !== m_exp_t()) begin n_err++; $display("FAIL rnd_t[%0d]: got %b want %b", i, T_out, m_exp_t()); end
      n_cmp++; if (tc !== (m_st == M_RUN && m_q == m_end())) begin n_err++; $display("FAIL rnd_tc[%0d]: got %b want %b", i, tc, (m_st == M_RUN && m_q == m_end())); end
      n_cmp++; if ({busy, done} !== {(m_st == M_RUN || m_st == M_PAUSE), (m_st == M_DONE)}) begin n_err++; $display("FAIL rnd_flags[%0d]: busy/done got %b/%b want %b/%b", i, busy, done, (m_st == M_RUN || m_st == M_PAUSE), (m_st == M_DONE)); end
      tick();
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  initial begin
    tick(); tick();
    test_reset();
    test_oneshot_up();
    test_wrap_down();
    test_pause_abort();
    test_start_stop_limit0();
    test_rst_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
